// File: rtl/led_pixel_serializer_pkg.sv
// Shared types for the WS2812 pixel serializer: FSM state encoding and the GRB pixel word.
package led_serializer_defs;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_SHIFT,
      SER_LATCH
   } serializer_state_t;

   typedef logic [23:0] pixel_t;

   localparam int PIXEL_BITS = 24;

endpackage

// File: rtl/led_pixel_serializer_bit_timer.sv
// One WS2812 bit period: counts cyc 0..BIT_CYCLES-1 and reports whether the line should be high.
module ws2812_bit_timer
   import led_serializer_defs::*;
#(
   parameter int T0H_CYCLES = 20,
   parameter int T1H_CYCLES = 40,
   parameter int BIT_CYCLES = 63
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic bit_val,
   output logic high,
   output logic bit_done
);

   localparam int CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] T0H_CMP  = CW'(T0H_CYCLES);
   localparam logic [CW-1:0] T1H_CMP  = CW'(T1H_CYCLES);

   logic [CW-1:0] cyc;
   logic          active;

   // start on the last cycle of a bit restarts at 0 so consecutive bits abut
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc    <= '0;
         active <= 1'b0;
      end else if (start) begin
         cyc    <= '0;
         active <= 1'b1;
      end else if (active) begin
         if (cyc == LAST_CYC) begin
            cyc    <= '0;
            active <= 1'b0;
         end else begin
            cyc <= cyc + 1'b1;
         end
      end
   end

   assign bit_done = active && (cyc == LAST_CYC);
   assign high     = active && (cyc < (bit_val ? T1H_CMP : T0H_CMP));

endmodule

// File: rtl/led_pixel_serializer.sv
// WS2812 output stage: one-entry pixel hold, 24-bit shifter, latch-gap timer and registered NRZ line.
module led_pixel_serializer
   import led_serializer_defs::*;
#(
   parameter int T0H_CYCLES   = 20,
   parameter int T1H_CYCLES   = 40,
   parameter int BIT_CYCLES   = 63,
   parameter int RESET_CYCLES = 15000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pixel_valid,
   input  logic [23:0] pixel_data,
   output logic        pixel_ready,
   input  logic        frame_end,
   output logic        busy,
   output logic        led_out
);

   localparam int GW = $clog2(RESET_CYCLES + 1);

   serializer_state_t state, state_nx;
   pixel_t            hold, shifter;
   logic              hold_full, latch_pending;
   logic [4:0]        bit_idx;
   logic [GW-1:0]     gap;
   logic              accept, load, timer_start;
   logic              bit_high, bit_done, last_bit, gap_done;

   // Handshake: a pixel transfers on a rising edge where pixel_valid && pixel_ready;
   // pixel_ready depends only on registers, so upstream may hold valid and data steady.
   assign pixel_ready = !hold_full && (state != SER_LATCH);
   assign accept      = pixel_valid && pixel_ready;
   assign busy        = (state != SER_IDLE) || hold_full || latch_pending;
   assign last_bit    = (bit_idx == 5'd0);
   assign gap_done    = (gap == GW'(RESET_CYCLES - 1));

   ws2812_bit_timer #(
      .T0H_CYCLES (T0H_CYCLES),
      .T1H_CYCLES (T1H_CYCLES),
      .BIT_CYCLES (BIT_CYCLES)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .start    (timer_start),
      .bit_val  (shifter[23]),
      .high     (bit_high),
      .bit_done (bit_done)
   );

   always_comb begin
      state_nx    = state;
      load        = 1'b0;
      timer_start = 1'b0;
      case (state)
         SER_IDLE: begin
            if (hold_full) begin
               load        = 1'b1;
               timer_start = 1'b1;
               state_nx    = SER_SHIFT;
            end else if (latch_pending) begin
               state_nx = SER_LATCH;
            end
         end
         SER_SHIFT: begin
            if (bit_done) begin
               if (!last_bit) begin
                  timer_start = 1'b1;
               end else if (hold_full) begin
                  // reload straight from hold so the next pixel follows without a gap
                  load        = 1'b1;
                  timer_start = 1'b1;
               end else if (latch_pending) begin
                  state_nx = SER_LATCH;
               end else begin
                  state_nx = SER_IDLE;
               end
            end
         end
         SER_LATCH: begin
            if (gap_done) state_nx = SER_IDLE;
         end
         default: state_nx = SER_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= SER_IDLE;
         hold          <= '0;
         hold_full     <= 1'b0;
         shifter       <= '0;
         bit_idx       <= '0;
         latch_pending <= 1'b0;
         gap           <= '0;
         led_out       <= 1'b0;
      end else begin
         state <= state_nx;

         if (accept) hold <= pixel_data;
         if (load)        hold_full <= 1'b0;
         else if (accept) hold_full <= 1'b1;

         if (load) begin
            shifter <= hold;
            bit_idx <= 5'(PIXEL_BITS - 1);
         end else if (state == SER_SHIFT && bit_done && !last_bit) begin
            shifter <= {shifter[22:0], 1'b0};
            bit_idx <= bit_idx - 5'd1;
         end

         // a frame_end arriving while the gap runs is absorbed by that gap
         if (state == SER_LATCH && gap_done)          latch_pending <= 1'b0;
         else if (frame_end && state != SER_LATCH)    latch_pending <= 1'b1;

         if (state == SER_LATCH) gap <= gap_done ? '0 : gap + 1'b1;
         else                    gap <= '0;

         led_out <= (state == SER_SHIFT) && bit_high;
      end
   end

endmodule
